// File: rtl/mem_boot_loader_pkg.sv
// Shared definitions for the boot loader: loader FSM encodings, default
// geometry tied to the BRAM depth, and the start-dispatch rule used by the
// loader FSM.
package mem_boot_loader_pkg;

    localparam int I_BRAM_DEPTH   = 256;
    localparam int LDR_DATA_WIDTH = 32;
    localparam int LDR_ADDR_WIDTH = 10;
    localparam int LDR_D_DEPTH    = I_BRAM_DEPTH;
    localparam int LDR_I_DEPTH    = I_BRAM_DEPTH;
    localparam int LDR_CNT_WIDTH  = 9;

    // Loads always begin at the bottom of each BRAM.
    localparam int BOOT_ADDR = 0;

    typedef enum logic [2:0] {
        LDR_IDLE   = 3'd0,
        LDR_LOAD_D = 3'd1,
        LDR_LOAD_I = 3'd2,
        LDR_RUN    = 3'd3,
        LDR_ERR    = 3'd4
    } ldr_state_t;

    // Where an accepted start sends the FSM. Over-depth counts win over
    // everything; empty regions are skipped.
    function automatic ldr_state_t ldr_dispatch(
        input int unsigned d_cnt,
        input int unsigned i_cnt,
        input int unsigned d_depth,
        input int unsigned i_depth
    );
        if (d_cnt > d_depth || i_cnt > i_depth) begin
            return LDR_ERR;
        end else if (d_cnt != 0) begin
            return LDR_LOAD_D;
        end else if (i_cnt != 0) begin
            return LDR_LOAD_I;
        end
        return LDR_RUN;
    endfunction

endpackage

// File: rtl/mem_boot_loader_ldr_write_port.sv
// Registered BRAM write-port generator for one region of the boot loader.
// Each accepted word produces a one-cycle write pulse on the following cycle
// at byte address idx*4, after which the word index advances.
//
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   clr        clear the word index (new load starting)
//   acc        a word for this region is accepted on this edge
//   data       word being accepted
//   idx        current word index (words already accepted in this load)
//   w_enb      BRAM write enable (one cycle per accepted word)
//   w_addr     BRAM write byte address
//   w_dat      BRAM write data
module mem_boot_loader_ldr_write_port
    import mem_boot_loader_pkg::*;
#(
    parameter int DATA_WIDTH = LDR_DATA_WIDTH,
    parameter int ADDR_WIDTH = LDR_ADDR_WIDTH,
    parameter int CNT_WIDTH  = LDR_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  acc,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [CNT_WIDTH-1:0]  idx,
    output logic                  w_enb,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [DATA_WIDTH-1:0] w_dat
);

    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            w_enb  <= 1'b0;
            w_addr <= '0;
            w_dat  <= '0;
        end else begin
            w_enb <= acc;
            if (clr) begin
                idx <= '0;
            end else if (acc) begin
                idx    <= idx + CNT_WIDTH'(1);
                // Word index to byte address; the cast trims to the port width.
                w_addr <= ADDR_WIDTH'({idx, 2'b00});
                w_dat  <= data;
            end
        end
    end

endmodule

// File: rtl/mem_boot_loader.sv
// Boot loader for the rv32i instruction and data BRAMs. Takes a valid/ready
// word stream and writes d_count words into the data BRAM followed by
// i_count words into the instruction BRAM, holding the core stalled until
// the load completes. Supports reload from RUN and rejects over-depth counts.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | out of reset, core stalled, waiting for start
// LOAD_D | streaming words into the data BRAM
// LOAD_I | streaming words into the instruction BRAM
// RUN    | load finished; core released one cycle after the last write
// ERR    | requested count exceeded a depth; waits for a legal start
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   start                load request pulse (honoured in IDLE, RUN, ERR)
//   d_count, i_count     word counts, captured on an accepted start
//   s_valid/s_data/s_ready  input word stream handshake
//   d_w_addr/d_w_dat/d_w_enb  data BRAM write port
//   i_w_addr/i_w_dat/i_w_enb  instruction BRAM write port
//   d_init_done          data region complete
//   pc_stall, rd_enbl    core stall / register-file read enable
//   busy, error          load in progress / over-depth request
module mem_boot_loader
    import mem_boot_loader_pkg::*;
#(
    parameter int DATA_WIDTH = LDR_DATA_WIDTH,
    parameter int ADDR_WIDTH = LDR_ADDR_WIDTH,
    parameter int D_DEPTH    = LDR_D_DEPTH,
    parameter int I_DEPTH    = LDR_I_DEPTH,
    parameter int CNT_WIDTH  = LDR_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  d_count,
    input  logic [CNT_WIDTH-1:0]  i_count,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] d_w_addr,
    output logic [DATA_WIDTH-1:0] d_w_dat,
    output logic                  d_w_enb,
    output logic [ADDR_WIDTH-1:0] i_w_addr,
    output logic [DATA_WIDTH-1:0] i_w_dat,
    output logic                  i_w_enb,
    output logic                  d_init_done,
    output logic                  pc_stall,
    output logic                  rd_enbl,
    output logic                  busy,
    output logic                  error
);

    ldr_state_t           state;
    ldr_state_t           dispatch;
    logic                 go;
    logic                 acc_d;
    logic                 acc_i;
    logic                 last_d;
    logic                 last_i;
    logic [CNT_WIDTH-1:0] cnt_d_q;
    logic [CNT_WIDTH-1:0] cnt_i_q;
    logic [CNT_WIDTH-1:0] idx_d;
    logic [CNT_WIDTH-1:0] idx_i;

    assign dispatch = ldr_dispatch(32'(d_count), 32'(i_count),
                                   32'(D_DEPTH), 32'(I_DEPTH));

    assign go     = start && (state == LDR_IDLE || state == LDR_RUN || state == LDR_ERR);
    assign acc_d  = s_valid && s_ready && (state == LDR_LOAD_D);
    assign acc_i  = s_valid && s_ready && (state == LDR_LOAD_I);
    // Counts are non-zero whenever the matching LOAD state is entered.
    assign last_d = (idx_d == cnt_d_q - CNT_WIDTH'(1));
    assign last_i = (idx_i == cnt_i_q - CNT_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LDR_IDLE;
            cnt_d_q     <= '0;
            cnt_i_q     <= '0;
            s_ready     <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b0;
            pc_stall    <= 1'b1;
            rd_enbl     <= 1'b0;
            d_init_done <= 1'b0;
        end else begin
            case (state)
                LDR_IDLE, LDR_RUN, LDR_ERR: begin
                    if (start) begin
                        state       <= dispatch;
                        s_ready     <= (dispatch == LDR_LOAD_D) || (dispatch == LDR_LOAD_I);
                        busy        <= (dispatch == LDR_LOAD_D) || (dispatch == LDR_LOAD_I);
                        error       <= (dispatch == LDR_ERR);
                        pc_stall    <= 1'b1;
                        rd_enbl     <= 1'b0;
                        d_init_done <= 1'b0;
                        if (dispatch != LDR_ERR) begin
                            cnt_d_q <= d_count;
                            cnt_i_q <= i_count;
                        end
                    end else if (state == LDR_RUN) begin
                        // First RUN cycle follows the final write pulse.
                        pc_stall    <= 1'b0;
                        rd_enbl     <= 1'b1;
                        d_init_done <= 1'b1;
                    end
                end

                LDR_LOAD_D: begin
                    if (acc_d && last_d) begin
                        if (cnt_i_q != '0) begin
                            state <= LDR_LOAD_I;
                        end else begin
                            state   <= LDR_RUN;
                            s_ready <= 1'b0;
                            busy    <= 1'b0;
                        end
                    end
                end

                LDR_LOAD_I: begin
                    // Any data writes have already been issued by now.
                    d_init_done <= 1'b1;
                    if (acc_i && last_i) begin
                        state   <= LDR_RUN;
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                    end
                end

                default: begin
                    state <= LDR_IDLE;
                end
            endcase
        end
    end

    mem_boot_loader_ldr_write_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_d_port (
        .clk    (clk),
        .rst    (rst),
        .clr    (go),
        .acc    (acc_d),
        .data   (s_data),
        .idx    (idx_d),
        .w_enb  (d_w_enb),
        .w_addr (d_w_addr),
        .w_dat  (d_w_dat)
    );

    mem_boot_loader_ldr_write_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_i_port (
        .clk    (clk),
        .rst    (rst),
        .clr    (go),
        .acc    (acc_i),
        .data   (s_data),
        .idx    (idx_i),
        .w_enb  (i_w_enb),
        .w_addr (i_w_addr),
        .w_dat  (i_w_dat)
    );

endmodule

// File: tb/tb_mem_boot_loader.sv
module tb_mem_boot_loader;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int DD = 256;
    localparam int ID = 256;
    localparam int CW = 9;

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_RUN  = 2;
    localparam int PH_ERR  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] d_count = '0;
    logic [CW-1:0] i_count = '0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic [AW-1:0] d_w_addr;
    logic [DW-1:0] d_w_dat;
    logic          d_w_enb;
    logic [AW-1:0] i_w_addr;
    logic [DW-1:0] i_w_dat;
    logic          i_w_enb;
    logic          d_init_done;
    logic          pc_stall;
    logic          rd_enbl;
    logic          busy;
    logic          error;

    mem_boot_loader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .d_count     (d_count),
        .i_count     (i_count),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .d_w_addr    (d_w_addr),
        .d_w_dat     (d_w_dat),
        .d_w_enb     (d_w_enb),
        .i_w_addr    (i_w_addr),
        .i_w_dat     (i_w_dat),
        .i_w_enb     (i_w_enb),
        .d_init_done (d_init_done),
        .pc_stall    (pc_stall),
        .rd_enbl     (rd_enbl),
        .busy        (busy),
        .error       (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the load as "how many words of the d+i total have been taken";
    // the region and byte address of each word follow from that number.
    int            m_phase = PH_IDLE;
    int            m_d = 0;
    int            m_i = 0;
    int            m_nacc = 0;
    int            cyc = 0;
    logic          e_ready, e_busy, e_err, e_stall, e_rd, e_dinit;
    logic          e_d_enb, e_i_enb;
    logic [AW-1:0] e_d_addr, e_i_addr;
    logic [DW-1:0] e_d_dat, e_i_dat;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_phase = PH_IDLE;
            e_ready = 0; e_busy = 0; e_err = 0; e_stall = 1; e_rd = 0; e_dinit = 0;
            e_d_enb = 0; e_i_enb = 0;
            e_d_addr = '0; e_d_dat = '0; e_i_addr = '0; e_i_dat = '0;
        end else begin
            e_d_enb = 0;
            e_i_enb = 0;
            if (m_phase != PH_LOAD) begin
                if (start) begin
                    if (int'(d_count) > DD || int'(i_count) > ID) begin
                        m_phase = PH_ERR;
                        e_err = 1;
                        e_ready = 0;
                        e_busy = 0;
                    end else begin
                        m_d = int'(d_count);
                        m_i = int'(i_count);
                        m_nacc = 0;
                        e_err = 0;
                        m_phase = (m_d + m_i == 0) ? PH_RUN : PH_LOAD;
                        e_ready = (m_phase == PH_LOAD);
                        e_busy = (m_phase == PH_LOAD);
                    end
                    e_stall = 1; e_rd = 0; e_dinit = 0;
                end else if (m_phase == PH_RUN) begin
                    e_stall = 0; e_rd = 1; e_dinit = 1;
                end
            end else begin
                if (m_nacc >= m_d) e_dinit = 1;
                if (s_valid) begin
                    if (m_nacc < m_d) begin
                        e_d_enb = 1;
                        e_d_addr = AW'(m_nacc * 4);
                        e_d_dat = s_data;
                    end else begin
                        e_i_enb = 1;
                        e_i_addr = AW'((m_nacc - m_d) * 4);
                        e_i_dat = s_data;
                    end
                    m_nacc++;
                    if (m_nacc == m_d + m_i) begin
                        m_phase = PH_RUN;
                        e_ready = 0;
                        e_busy = 0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare + write log ----------------
    bit            chk_en = 0;
    logic [AW-1:0] d_log_addr[$];
    logic [DW-1:0] d_log_dat[$];
    int            d_log_cyc[$];
    logic [AW-1:0] i_log_addr[$];
    logic [DW-1:0] i_log_dat[$];
    int            i_log_cyc[$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("s_ready", s_ready, e_ready);
            chk("busy", busy, e_busy);
            chk("error", error, e_err);
            chk("pc_stall", pc_stall, e_stall);
            chk("rd_enbl", rd_enbl, e_rd);
            chk("d_init_done", d_init_done, e_dinit);
            chk("d_w_enb", d_w_enb, e_d_enb);
            chk("i_w_enb", i_w_enb, e_i_enb);
            if (e_d_enb) begin
                chk("d_w_addr", d_w_addr, e_d_addr);
                chk("d_w_dat", d_w_dat, e_d_dat);
            end
            if (e_i_enb) begin
                chk("i_w_addr", i_w_addr, e_i_addr);
                chk("i_w_dat", i_w_dat, e_i_dat);
            end
        end
        if (d_w_enb === 1'b1) begin
            d_log_addr.push_back(d_w_addr); d_log_dat.push_back(d_w_dat); d_log_cyc.push_back(cyc);
        end
        if (i_w_enb === 1'b1) begin
            i_log_addr.push_back(i_w_addr); i_log_dat.push_back(i_w_dat); i_log_cyc.push_back(cyc);
        end
    end

    // ---------------- stimulus helpers ----------------
    int          str_mode = 0;   // 0 off, 1 continuous, 2 toggle, 3 random 50%
    logic [31:0] word_base = '0;

    task automatic drive_stream();
        case (str_mode)
            0: s_valid = 1'b0;
            1: s_valid = 1'b1;
            2: s_valid = ~s_valid;
            default: s_valid = ($urandom_range(0, 99) < 50);
        endcase
        s_data = s_valid ? (word_base + 32'(m_nacc)) : $urandom;
    endtask

    task automatic tick();
        @(negedge clk);
        drive_stream();
        start = 1'b0;
        d_count = CW'($urandom);
        i_count = CW'($urandom);
    endtask

    task automatic pulse_start(input int d, input int i);
        @(negedge clk);
        drive_stream();
        start = 1'b1;
        d_count = CW'(d);
        i_count = CW'(i);
        tick();
    endtask

    task automatic wait_done(input int bound);
        int k;
        k = 0;
        while ((busy || m_phase == PH_LOAD) && k < bound) begin
            tick();
            k++;
        end
        chk("load_done_timeout", busy, 0);
    endtask

    task automatic clear_logs();
        d_log_addr.delete(); d_log_dat.delete(); d_log_cyc.delete();
        i_log_addr.delete(); i_log_dat.delete(); i_log_cyc.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_d_w_enb"}, d_w_enb, 0);
        chk({tag, "_d_w_addr"}, d_w_addr, 0);
        chk({tag, "_d_w_dat"}, d_w_dat, 0);
        chk({tag, "_i_w_enb"}, i_w_enb, 0);
        chk({tag, "_i_w_addr"}, i_w_addr, 0);
        chk({tag, "_i_w_dat"}, i_w_dat, 0);
        chk({tag, "_d_init_done"}, d_init_done, 0);
        chk({tag, "_pc_stall"}, pc_stall, 1);
        chk({tag, "_rd_enbl"}, rd_enbl, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1;
        chk_reset_outputs("reset");

        // 1: 10 data + 3 instruction words, continuous stream
        clear_logs();
        str_mode = 1;
        word_base = 32'h100;
        pulse_start(10, 3);
        wait_done(100);
        chk("t1_last_i_write_visible", i_w_enb, 1);
        chk("t1_stall_at_run_entry", pc_stall, 1);
        tick();
        chk("t1_stall_falls", pc_stall, 0);
        chk("t1_rd_enbl", rd_enbl, 1);
        repeat (2) tick();
        chk("t1_d_writes", d_log_addr.size(), 10);
        chk("t1_i_writes", i_log_addr.size(), 3);
        if (d_log_addr.size() == 10 && i_log_addr.size() == 3) begin
            chk("t1_d_last_addr", d_log_addr[9], 10'h024);
            chk("t1_d_last_dat", d_log_dat[9], 32'h109);
            chk("t1_i0_addr", i_log_addr[0], 10'h000);
            chk("t1_i2_addr", i_log_addr[2], 10'h008);
            chk("t1_i2_dat", i_log_dat[2], 32'h10C);
            chk("t1_span", i_log_cyc[2] - d_log_cyc[0], 12);
        end

        // 2: same counts with s_valid toggling every cycle (reload from RUN)
        clear_logs();
        str_mode = 2;
        pulse_start(10, 3);
        wait_done(100);
        repeat (3) tick();
        chk("t2_d_writes", d_log_addr.size(), 10);
        chk("t2_i_writes", i_log_addr.size(), 3);
        for (int k = 0; k < d_log_addr.size() && k < 10; k++) begin
            chk("t2_d_addr", d_log_addr[k], AW'(4 * k));
            chk("t2_d_dat", d_log_dat[k], 32'h100 + 32'(k));
        end
        for (int k = 0; k < i_log_addr.size() && k < 3; k++) begin
            chk("t2_i_addr", i_log_addr[k], AW'(4 * k));
            chk("t2_i_dat", i_log_dat[k], 32'h10A + 32'(k));
        end

        // 3: empty load, then instruction-only load
        clear_logs();
        str_mode = 1;
        pulse_start(0, 0);
        chk("t3_empty_busy", busy, 0);
        repeat (2) tick();
        chk("t3_empty_stall", pc_stall, 0);
        chk("t3_empty_writes", d_log_addr.size() + i_log_addr.size(), 0);
        pulse_start(0, 2);
        wait_done(50);
        chk("t3_dinit_at_run", d_init_done, 1);
        repeat (2) tick();
        chk("t3_d_writes", d_log_addr.size(), 0);
        chk("t3_i_writes", i_log_addr.size(), 2);
        if (i_log_addr.size() == 2) chk("t3_i1_addr", i_log_addr[1], 10'h004);

        // 4: over-depth request, then recovery with legal counts
        clear_logs();
        pulse_start(DD + 1, 1);
        chk("t4_error", error, 1);
        chk("t4_s_ready", s_ready, 0);
        chk("t4_pc_stall", pc_stall, 1);
        repeat (3) tick();
        pulse_start(1, 1);
        chk("t4_error_clear", error, 0);
        wait_done(50);
        repeat (2) tick();
        chk("t4_writes", d_log_addr.size() * 10 + i_log_addr.size(), 11);

        // 5: reset in the middle of the data region
        clear_logs();
        word_base = 32'h200;
        pulse_start(10, 3);
        for (int k = 0; k < 20 && d_log_addr.size() < 4; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs("t5_midrst");
        clear_logs();
        word_base = 32'h300;
        pulse_start(3, 2);
        wait_done(50);
        repeat (2) tick();
        chk("t5_d_writes", d_log_addr.size(), 3);
        if (d_log_addr.size() > 0) begin
            chk("t5_first_addr", d_log_addr[0], 10'h000);
            chk("t5_first_dat", d_log_dat[0], 32'h300);
        end

        // 6: reload from RUN
        clear_logs();
        repeat (2) tick();
        pulse_start(2, 1);
        chk("t6_stall_reasserted", pc_stall, 1);
        chk("t6_dinit_cleared", d_init_done, 0);
        wait_done(50);
        repeat (2) tick();
        chk("t6_writes", d_log_addr.size() * 10 + i_log_addr.size(), 21);
        chk("t6_run_again", pc_stall, 0);

        // randomized loads, including full depth, over-depth and ignored starts
        for (int it = 0; it < 20; it++) begin
            int d, i, sel;
            sel = $urandom_range(0, 9);
            d = $urandom_range(0, 20);
            i = $urandom_range(0, 20);
            if (sel == 0) d = DD;
            if (sel == 1) i = ID;
            if (sel == 2) d = $urandom_range(DD + 1, 511);
            if (sel == 3) i = $urandom_range(ID + 1, 511);
            str_mode = $urandom_range(1, 3);
            word_base = $urandom;
            pulse_start(d, i);
            if (sel == 4) begin
                repeat (2) tick();
                pulse_start($urandom_range(0, 300), $urandom_range(0, 300));
            end
            wait_done(3000);
            repeat ($urandom_range(1, 4)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
